// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Holds the funct3 op encoding, the FSM states and the iteration count.
package muldiv_unit_pkg;

    localparam int ITER = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the pipeline (master) and the mul/div unit (slave).
// start/op/A/B/kill flow in; busy/done/Result flow back.
interface muldiv_unit_if #(parameter int DATA_WIDTH = 32);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  kill;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] Result;

    modport master (output start, op, A, B, kill, input busy, done, Result);
    modport slave  (input start, op, A, B, kill, output busy, done, Result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add and restoring division on one shared adder.
// Latency: done 33 cycles after start (1 cycle for divide-by-zero / signed overflow).
// Backpressure: busy stalls the pipeline; start is ignored unless idle, kill aborts at once.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int W = DATA_WIDTH;

    state_e         state;
    op_e            op_q;
    logic [4:0]     cnt;
    logic [2*W-1:0] acc;     // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]   opb;
    logic           sign_a;
    logic           sign_b;

    op_e          op_in;
    logic         in_sa, in_sb;
    logic [W-1:0] abs_a, abs_b;
    logic         div_zero, div_ovf;
    logic [W-1:0] fast_res;

    always_comb begin
        op_in    = op_e'(bus.op);
        in_sa    = bus.A[W-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        in_sb    = bus.B[W-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
        abs_a    = in_sa ? -bus.A : bus.A;
        abs_b    = in_sb ? -bus.B : bus.B;
        div_zero = op_in[2] && (bus.B == '0);
        div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                   (bus.A == {1'b1, {(W-1){1'b0}}}) && (bus.B == '1);
        if (div_zero)
            fast_res = op_in[1] ? bus.A : '1;
        else
            fast_res = op_in[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end

    // Single adder: add for shift-add, subtract (invert + carry-in) for restoring division.
    logic         add_sub;
    logic [W:0]   add_x, add_y;
    logic [W+1:0] add_sum;
    logic         no_borrow;
    logic [2*W-1:0] acc_nxt;

    always_comb begin
        add_sub   = (state == S_DIV);
        add_x     = add_sub ? acc[2*W-1:W-1] : {1'b0, acc[2*W-1:W]};
        add_y     = {1'b0, opb};
        add_sum   = {1'b0, add_x} + {1'b0, add_y ^ {(W+1){add_sub}}} + {{(W+1){1'b0}}, add_sub};
        no_borrow = add_sum[W+1];
        if (add_sub)
            acc_nxt = no_borrow ? {add_sum[W-1:0], acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};
        else
            acc_nxt = acc[0] ? {add_sum[W:0], acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
    end

    logic           neg_qp;
    logic [2*W-1:0] prod_f;
    logic [W-1:0]   quot_f, rem_f, fin_res;

    always_comb begin
        neg_qp = sign_a ^ sign_b;
        prod_f = neg_qp ? -acc_nxt : acc_nxt;
        quot_f = neg_qp ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
        rem_f  = sign_a ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
        if (!op_q[2])
            fin_res = (op_q == OP_MUL) ? prod_f[W-1:0] : prod_f[2*W-1:W];
        else
            fin_res = op_q[1] ? rem_f : quot_f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= OP_MUL;
            cnt        <= '0;
            acc        <= '0;
            opb        <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.Result <= '0;
        end else if (bus.kill) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        op_q     <= op_in;
                        sign_a   <= in_sa;
                        sign_b   <= in_sb;
                        opb      <= abs_b;
                        acc      <= {{W{1'b0}}, abs_a};
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        if (div_zero || div_ovf) begin
                            state      <= S_FIN;
                            bus.done   <= 1'b1;
                            bus.Result <= fast_res;
                        end else begin
                            state <= op_in[2] ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(ITER - 1)) begin
                        state      <= S_FIN;
                        cnt        <= '0;
                        bus.done   <= 1'b1;
                        bus.Result <= fin_res;
                    end
                end
                S_FIN: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expectations are queued at start and popped at done.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_res;

    typedef struct { logic [31:0] res; int lat; } exp_t;
    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; int lat; } vec_t;
    exp_t sb[$];

    muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got still running, want finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, su;
        logic [63:0] p;
        logic signed [31:0] sa32, sb32;
        logic ovf;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        su   = {32'd0, b};
        sa32 = a;
        sb32 = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = 64'd0;
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * su; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return 32'h8000_0000; return sa32 / sb32; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; if (ovf) return 32'd0; return sa32 % sb32; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Drives a start in the current cycle (cycle 0) and queues its expectation.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
        exp_t e;
        e.res = res;
        e.lat = lat;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
    endtask

    // Steps cycles until done or limit; operands are scrambled after the start cycle.
    task automatic wait_done(input int limit, output int cyc, output bit seen, output int busy_low);
        cyc = 0;
        seen = 1'b0;
        busy_low = 0;
        while (!seen && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                bus.start = 1'b0;
                bus.op    = 3'($urandom);
                bus.A     = $urandom;
                bus.B     = $urandom;
            end
            if (!bus.busy) busy_low++;
            if (bus.done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.op    = 3'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        #3;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++;
        if (bus.Result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.Result); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_res = 32'd0;
    endtask

    task automatic test_directed();
        vec_t vecs[$];
        exp_t e;
        int cyc, blow;
        bit seen;
        vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{3'd2, 32'hFFFF_FFFE,  32'h8000_0000, 32'hFFFF_FFFF, 33});
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
            wait_done(40, cyc, seen, blow);
            e = sb.pop_front();
            checks++;
            if (!seen || cyc != e.lat) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d (seen=%0b) want %0d", i, cyc, seen, e.lat);
            end
            checks++;
            if (bus.Result !== e.res) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, bus.Result, e.res); end
            checks++;
            if (blow != 0) begin errors++; $display("FAIL dir%0d_busy: got %0d busy-low cycles want 0", i, blow); end
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_after_done: got done=%b busy=%b want 0 0", i, bus.done, bus.busy);
            end
            checks++;
            if (bus.Result !== e.res) begin errors++; $display("FAIL dir%0d_hold: got %h want %h", i, bus.Result, e.res); end
            last_res = e.res;
        end
    endtask

    task automatic test_kill();
        exp_t e;
        int cyc, blow;
        bit seen;
        issue(3'd5, 32'd1000, 32'd7, 32'd142, 33);
        wait_done(10, cyc, seen, blow);
        void'(sb.pop_front());
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL kill_busy: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.Result !== last_res) begin errors++; $display("FAIL kill_result: got %h want %h", bus.Result, last_res); end
        wait_done(40, cyc, seen, blow);
        checks++;
        if (seen) begin errors++; $display("FAIL kill_no_done: got done at cycle %0d want none", cyc); end
        // kill and start together in IDLE: nothing accepted
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        bus.op    = 3'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL kill_start_busy: got %b want 0", bus.busy); end
        wait_done(40, cyc, seen, blow);
        checks++;
        if (seen) begin errors++; $display("FAIL kill_start_no_done: got done at cycle %0d want none", cyc); end
        issue(3'd0, 32'd3, 32'd4, 32'd12, 33);
        wait_done(40, cyc, seen, blow);
        e = sb.pop_front();
        checks++;
        if (!seen || cyc != e.lat || bus.Result !== e.res) begin
            errors++;
            $display("FAIL kill_then_mul: got cyc=%0d seen=%0b res=%h want cyc=%0d res=%h", cyc, seen, bus.Result, e.lat, e.res);
        end
        last_res = e.res;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int cyc, blow;
        bit seen;
        issue(3'd0, 32'd5, 32'd6, 32'd30, 33);
        wait_done(20, cyc, seen, blow);
        void'(sb.pop_front());
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got busy=%b done=%b res=%h want 0 0 0", bus.busy, bus.done, bus.Result);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_done(40, cyc, seen, blow);
        checks++;
        if (seen) begin errors++; $display("FAIL reset_mid_no_done: got done at cycle %0d want none", cyc); end
        last_res = 32'd0;
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int c1, c2, blow;
        bit seen;
        issue(3'd0, 32'd3, 32'd4, 32'd12, 33);
        wait_done(5, c1, seen, blow);
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.A     = 32'd100;
        bus.B     = 32'd0;
        wait_done(40, c2, seen, blow);
        e = sb.pop_front();
        checks++;
        if (!seen || (c1 + c2) != e.lat || bus.Result !== e.res) begin
            errors++;
            $display("FAIL ignore_start: got cyc=%0d res=%h want cyc=%0d res=%h", c1 + c2, bus.Result, e.lat, e.res);
        end
        wait_done(40, c2, seen, blow);
        checks++;
        if (seen) begin errors++; $display("FAIL ignore_start_extra_done: got done at cycle %0d want none", c2); end
        last_res = e.res;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int cyc, blow;
        bit seen;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom);
            a  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom);
            issue(op, a, b, model(op, a, b), model_lat(op, a, b));
            wait_done(40, cyc, seen, blow);
            e = sb.pop_front();
            checks++;
            if (!seen || cyc != e.lat || bus.Result !== e.res) begin
                errors++;
                $display("FAIL b2b%0d op=%0d a=%h b=%h: got cyc=%0d res=%h want cyc=%0d res=%h",
                         i, op, a, b, cyc, bus.Result, e.lat, e.res);
            end
            last_res = e.res;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_kill();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
